// File: rtl/systolic_skew_feeder_if.sv
// Operand/stream bundle between the matrix source and the skew feeder.
// master: matrix source (drives start and operands, observes the stream).
// slave : skew feeder (captures operands, drives the skewed edge lanes).
interface systolic_skew_feeder_if #(
    parameter int DATA_W = 8,
    parameter int N      = 3
);
    logic                       start;
    logic [N*N*DATA_W-1:0]      a_mat;
    logic [N*N*DATA_W-1:0]      b_mat;
    logic [N*DATA_W-1:0]        a_skew;
    logic [N*DATA_W-1:0]        b_skew;
    logic                       valid;
    logic                       clear_acc;
    logic                       busy;
    logic                       done;

    modport master (
        output start, a_mat, b_mat,
        input  a_skew, b_skew, valid, clear_acc, busy, done
    );

    modport slave (
        input  start, a_mat, b_mat,
        output a_skew, b_skew, valid, clear_acc, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for an N x N systolic MAC array.
// Captures A and B on start, pulses clear_acc, streams 2N-1 diagonal-skewed
// slots (A row r and B column c delayed by r and c cycles), then idles the
// lanes for DRAIN_CYC cycles and pulses done.
// Optional feature macro: FEEDER_STALL_EN adds a stall input that freezes
// sequencing in FEED/DRAIN (lanes hold, valid drops, no slot lost).
module systolic_skew_feeder #(
    parameter int DATA_W    = 8,
    parameter int N         = 3,
    parameter int DRAIN_CYC = 6
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef FEEDER_STALL_EN
    input  logic                 stall,
`endif
    systolic_skew_feeder_if.slave bus
);
    localparam int SLOTS = 2*N - 1;
    localparam int T_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int D_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(SLOTS - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_r, state_n_s;
    logic [T_W-1:0]          t_r, t_s;
    logic [D_W-1:0]          d_r, d_s;
    logic [N*N*DATA_W-1:0]   a_cap_r, b_cap_r;
    logic [N*DATA_W-1:0]     a_skew_r, a_skew_s, b_skew_r, b_skew_s;
    logic [N*DATA_W-1:0]     a_lane_s, b_lane_s;
    logic                    valid_r, valid_s, clear_acc_r, clear_acc_s;
    logic                    busy_r, busy_s, done_r, done_s, load_s;
    logic                    stall_s;

`ifdef FEEDER_STALL_EN
    // Stall only matters while sequencing; IDLE (and start capture) ignores it.
    assign stall_s = stall && (state_r != ST_IDLE);
`else
    assign stall_s = 1'b0;
`endif

    assign bus.a_skew    = a_skew_r;
    assign bus.b_skew    = b_skew_r;
    assign bus.valid     = valid_r;
    assign bus.clear_acc = clear_acc_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    // Diagonal lane select: lane r carries A[r][t-r], lane c carries B[t-c][c].
    always_comb begin : lane_sel
        int k;
        k        = 0;
        a_lane_s = '0;
        b_lane_s = '0;
        for (int r = 0; r < N; r++) begin
            k = int'(t_r) - r;
            if (k >= 0 && k < N) begin
                a_lane_s[r*DATA_W +: DATA_W] = a_cap_r[(r*N + k)*DATA_W +: DATA_W];
                b_lane_s[r*DATA_W +: DATA_W] = b_cap_r[(k*N + r)*DATA_W +: DATA_W];
            end else begin
                a_lane_s[r*DATA_W +: DATA_W] = '0;
                b_lane_s[r*DATA_W +: DATA_W] = '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state decode: FEED ends after the last slot, DRAIN after the last drain cycle.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_n_s = ST_FEED;
                else           state_n_s = ST_IDLE;
            end
            ST_FEED: begin
                if (!stall_s && t_r == T_LAST) state_n_s = ST_DRAIN;
                else                           state_n_s = ST_FEED;
            end
            ST_DRAIN: begin
                if (!stall_s && d_r == D_LAST) state_n_s = ST_IDLE;
                else                           state_n_s = ST_DRAIN;
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Output/counter decode: next values of every registered output and counter.
    always_comb begin
        t_s         = t_r;
        d_s         = d_r;
        a_skew_s    = a_skew_r;
        b_skew_s    = b_skew_r;
        valid_s     = 1'b0;
        clear_acc_s = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                a_skew_s = '0;
                b_skew_s = '0;
                if (bus.start) begin
                    load_s      = 1'b1;
                    clear_acc_s = 1'b1;
                    busy_s      = 1'b1;
                    t_s         = '0;
                    d_s         = '0;
                end else begin
                    busy_s      = 1'b0;
                end
            end
            ST_FEED: begin
                if (stall_s) begin
                    valid_s = 1'b0;
                end else begin
                    a_skew_s = a_lane_s;
                    b_skew_s = b_lane_s;
                    valid_s  = 1'b1;
                    d_s      = '0;
                    if (t_r == T_LAST) t_s = '0;
                    else               t_s = t_r + T_W'(1);
                end
            end
            ST_DRAIN: begin
                if (stall_s) begin
                    valid_s = 1'b0;
                end else begin
                    a_skew_s = '0;
                    b_skew_s = '0;
                    if (d_r == D_LAST) begin
                        d_s    = '0;
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end else begin
                        d_s    = d_r + D_W'(1);
                    end
                end
            end
            default: begin
                a_skew_s = '0;
                b_skew_s = '0;
                busy_s   = 1'b0;
                t_s      = '0;
                d_s      = '0;
            end
        endcase
    end

    // Datapath registers: operand capture, counters and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cap_r     <= '0;
            b_cap_r     <= '0;
            t_r         <= '0;
            d_r         <= '0;
            a_skew_r    <= '0;
            b_skew_r    <= '0;
            valid_r     <= 1'b0;
            clear_acc_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (load_s) begin
                a_cap_r <= bus.a_mat;
                b_cap_r <= bus.b_mat;
            end else begin
                a_cap_r <= a_cap_r;
                b_cap_r <= b_cap_r;
            end
            t_r         <= t_s;
            d_r         <= d_s;
            a_skew_r    <= a_skew_s;
            b_skew_r    <= b_skew_s;
            valid_r     <= valid_s;
            clear_acc_r <= clear_acc_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder with a slot-count reference model.
module tb_systolic_skew_feeder;
    localparam int DW = 8;
    localparam int N  = 3;
    localparam int DRAIN = 6;
    localparam int OW = 2*N*DW + 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    int   ncomp = 0;
    int   nfail = 0;

    systolic_skew_feeder_if #(.DATA_W(DW), .N(N)) bif ();

    systolic_skew_feeder #(.DATA_W(DW), .N(N), .DRAIN_CYC(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef FEEDER_STALL_EN
        .stall (stall),
`endif
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Reference model state: captured matrices and edges progressed since acceptance.
    logic [DW-1:0]   mA [N][N];
    logic [DW-1:0]   mB [N][N];
    logic            m_run;
    int              m_p;
    logic [N*DW-1:0] exp_a, exp_b;
    logic            exp_valid, exp_clear, exp_busy, exp_done;
    logic            stall_now;

`ifdef FEEDER_STALL_EN
    assign stall_now = stall;
`else
    assign stall_now = 1'b0;
`endif

    wire [OW-1:0] obs_w = {bif.a_skew, bif.b_skew, bif.valid, bif.clear_acc, bif.busy, bif.done};
    wire [OW-1:0] exp_w = {exp_a, exp_b, exp_valid, exp_clear, exp_busy, exp_done};

    function automatic logic [N*DW-1:0] lanes_a(int s);
        logic [N*DW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            if (s - r >= 0 && s - r < N) v[r*DW +: DW] = mA[r][s-r];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] lanes_b(int s);
        logic [N*DW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++)
            if (s - c >= 0 && s - c < N) v[c*DW +: DW] = mB[s-c][c];
        return v;
    endfunction

    // Model: edge 1 accepts, edges 2..2N stream slots, edge 2N+DRAIN signals done.
    always @(posedge clk) begin
        if (reset) begin
            m_run <= 1'b0; m_p <= 0;
            exp_a <= '0; exp_b <= '0;
            exp_valid <= 1'b0; exp_clear <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b0;
        end else if (!m_run) begin
            exp_a <= '0; exp_b <= '0; exp_valid <= 1'b0; exp_done <= 1'b0;
            if (bif.start) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        mA[r][c] <= bif.a_mat[(r*N+c)*DW +: DW];
                        mB[r][c] <= bif.b_mat[(r*N+c)*DW +: DW];
                    end
                m_run <= 1'b1; m_p <= 1; exp_clear <= 1'b1; exp_busy <= 1'b1;
            end else begin
                exp_clear <= 1'b0; exp_busy <= 1'b0;
            end
        end else begin
            exp_clear <= 1'b0;
            if (stall_now) begin
                exp_valid <= 1'b0;
            end else begin
                m_p <= m_p + 1;
                if (m_p + 1 <= 2*N) begin
                    exp_a <= lanes_a(m_p - 1); exp_b <= lanes_b(m_p - 1); exp_valid <= 1'b1;
                end else begin
                    exp_a <= '0; exp_b <= '0; exp_valid <= 1'b0;
                    if (m_p + 1 == 2*N + DRAIN) begin
                        exp_done <= 1'b1; exp_busy <= 1'b0; m_run <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic rand_mats();
        for (int i = 0; i < N*N; i++) begin
            bif.a_mat[i*DW +: DW] = DW'($urandom);
            bif.b_mat[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bif.start = 1'b0; bif.a_mat = '0; bif.b_mat = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            ncomp++;
            if (obs_w !== exp_w || obs_w !== '0) begin
                nfail++; $display("FAIL reset_idle cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
    endtask

    task automatic test_directed();
        int done_at, vcnt;
        done_at = -1; vcnt = 0;
        for (int i = 0; i < N*N; i++) begin
            bif.a_mat[i*DW +: DW] = DW'(i + 1);
            bif.b_mat[i*DW +: DW] = DW'(10*(i + 1));
        end
        bif.start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (bif.valid) vcnt++;
            if (bif.done && done_at < 0) done_at = k;
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL directed cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
            if (k == 1) begin
                ncomp++;
                if (bif.clear_acc !== 1'b1 || bif.busy !== 1'b1) begin
                    nfail++; $display("FAIL clear_acc: got clr=%b busy=%b want 1 1", bif.clear_acc, bif.busy);
                end
            end
            if (k == 2 || k == 4 || k == 6) begin
                logic [2*N*DW-1:0] want;
                if (k == 2)      want = {24'h000001, 24'h00000a};
                else if (k == 4) want = {8'd7, 8'd5, 8'd3, 8'd30, 8'd50, 8'd70};
                else             want = {8'd9, 8'd0, 8'd0, 8'd90, 8'd0, 8'd0};
                ncomp++;
                if ({bif.a_skew, bif.b_skew} !== want) begin
                    nfail++; $display("FAIL slot_t%0d: got %h want %h", k-2, {bif.a_skew, bif.b_skew}, want);
                end
            end
        end
        ncomp++;
        if (done_at != 12 || vcnt != 5) begin
            nfail++; $display("FAIL done_latency: got done@%0d valid=%0d want 12 5", done_at, vcnt);
        end
    endtask

    task automatic test_restart_ignored();
        int dones;
        dones = 0;
        rand_mats(); bif.start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            bif.start = (k == 3 || k == 4);
            if (k == 3) rand_mats();
            if (bif.done) dones++;
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL restart_ignored cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        ncomp++;
        if (dones != 1) begin
            nfail++; $display("FAIL single_done: got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int dones, clr_after;
        dones = 0; clr_after = 0;
        rand_mats(); bif.start = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            if (k > 12 && bif.clear_acc) clr_after = k;
            bif.start = 1'b0;
            if (bif.done) begin
                dones++;
                if (dones == 1) begin rand_mats(); bif.start = 1'b1; end
            end
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL back_to_back cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        ncomp++;
        if (dones != 2 || clr_after != 13) begin
            nfail++; $display("FAIL b2b_seq: got dones=%0d clr@%0d want 2 13", dones, clr_after);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        rand_mats(); bif.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (k == 5) begin
                ncomp++;
                if (obs_w !== '0) begin
                    nfail++; $display("FAIL reset_mid_zero: got %h want 0", obs_w);
                end
                reset = 1'b0;
            end
            if (k == 4) reset = 1'b1;
            if (bif.done) dones++;
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL reset_mid cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        ncomp++;
        if (dones != 0) begin
            nfail++; $display("FAIL reset_mid_nodone: got %0d want 0", dones);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            bif.start = ($urandom_range(0, 3) == 0);
            rand_mats();
            @(posedge clk); #1;
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL random cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        bif.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

`ifdef FEEDER_STALL_EN
    task automatic test_stall();
        int done_at;
        done_at = -1;
        for (int i = 0; i < N*N; i++) bif.a_mat[i*DW +: DW] = DW'(i + 1);
        bif.start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (bif.done && done_at < 0) done_at = k;
            if (k == 5) begin
                ncomp++;
                if (bif.a_skew !== {8'd0, 8'd4, 8'd2} || bif.valid !== 1'b0) begin
                    nfail++; $display("FAIL stall_hold: got a=%h v=%b want 000402 0", bif.a_skew, bif.valid);
                end
            end
            stall = (k >= 3 && k < 6);
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL stall cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        ncomp++;
        if (done_at != 15) begin
            nfail++; $display("FAIL stall_done_delay: got %0d want 15", done_at);
        end
        for (int k = 0; k < 200; k++) begin
            bif.start = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 2) == 0);
            rand_mats();
            @(posedge clk); #1;
            ncomp++;
            if (obs_w !== exp_w) begin
                nfail++; $display("FAIL stall_random cyc%0d: got %h want %h", k, obs_w, exp_w);
            end
        end
        stall = 1'b0; bif.start = 1'b0;
    endtask
`endif

    // Test sequence and summary.
    initial begin
        test_reset();
        test_directed();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef FEEDER_STALL_EN
        test_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
